// File: rtl/pbus_master_pkg.sv
// pbus_master_pkg: shared definitions for the pbus master.
//   state_t                        - transfer FSM states (IDLE/SETUP/ACCESS/RESP)
//   DEFAULT_TIMEOUT_CYCLES, DEFAULT_TO_W - default ACCESS-phase timeout settings
package pbus_master_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } state_t;

    localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 255;
    localparam int unsigned DEFAULT_TO_W           = 8;

endpackage

// File: rtl/pbus_master.sv
// pbus_master: APB-like bus master driving the pbus bridge slave port.
// Accepts one read/write command at a time, runs SETUP then ACCESS, supervises
// ACCESS with a ready-timeout and returns the result on a response channel.
//   pbus_clk, pbus_rst          - clock, synchronous active-high reset
//   cmd_*                       - host command channel (valid/ready)
//   rsp_*                       - response channel (valid/ready): rdata, err, timeout
//   pbus_addr/write/wdata/sel/enable_o - APB request outputs (all registered)
//   pbus_rdata/ready/slverr_i   - APB completion inputs
// TIMEOUT_CYCLES = 0 disables the timeout; TIMEOUT_CYCLES must be < 2**TO_W.
module pbus_master
    import pbus_master_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
    parameter int unsigned TO_W           = DEFAULT_TO_W
) (
    input  logic        pbus_clk,
    input  logic        pbus_rst,
    input  logic        cmd_valid_i,
    output logic        cmd_ready_o,
    input  logic        cmd_write_i,
    input  logic [31:0] cmd_addr_i,
    input  logic [31:0] cmd_wdata_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [31:0] rsp_rdata_o,
    output logic        rsp_err_o,
    output logic        rsp_timeout_o,
    output logic [31:0] pbus_addr_o,
    output logic        pbus_write_o,
    output logic        pbus_sel_o,
    output logic        pbus_enable_o,
    output logic [31:0] pbus_wdata_o,
    input  logic [31:0] pbus_rdata_i,
    input  logic        pbus_ready_i,
    input  logic        pbus_slverr_i
);

    localparam bit TO_ENABLED = (TIMEOUT_CYCLES != 0);
    localparam logic [TO_W-1:0] TO_LAST =
        TO_W'(TO_ENABLED ? TIMEOUT_CYCLES - 1 : 0);

    state_t          state;
    logic [TO_W-1:0] to_cnt;
    logic            to_hit;

    // Counter holds the number of not-ready ACCESS cycles already seen, so it
    // equals TIMEOUT_CYCLES-1 during the TIMEOUT_CYCLES-th ACCESS cycle.
    assign to_hit = TO_ENABLED && !pbus_ready_i && (to_cnt == TO_LAST);

    // cmd_ready/sel/enable/rsp_valid are registered alongside the state so each
    // is a flop that tracks the state decode without combinational paths.
    always_ff @(posedge pbus_clk) begin
        if (pbus_rst) begin
            state         <= ST_IDLE;
            cmd_ready_o   <= 1'b1;
            rsp_valid_o   <= 1'b0;
            rsp_rdata_o   <= '0;
            rsp_err_o     <= 1'b0;
            rsp_timeout_o <= 1'b0;
            pbus_addr_o   <= '0;
            pbus_write_o  <= 1'b0;
            pbus_wdata_o  <= '0;
            pbus_sel_o    <= 1'b0;
            pbus_enable_o <= 1'b0;
            to_cnt        <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (cmd_valid_i) begin
                        cmd_ready_o <= 1'b0;
                        if (cmd_addr_i[1:0] == 2'b00) begin
                            pbus_addr_o  <= cmd_addr_i;
                            pbus_write_o <= cmd_write_i;
                            pbus_wdata_o <= cmd_wdata_i;
                            pbus_sel_o   <= 1'b1;
                            state        <= ST_SETUP;
                        end else begin
                            // Misaligned: answer directly, never touch the bus.
                            rsp_valid_o   <= 1'b1;
                            rsp_rdata_o   <= '0;
                            rsp_err_o     <= 1'b1;
                            rsp_timeout_o <= 1'b0;
                            state         <= ST_RESP;
                        end
                    end
                end
                ST_SETUP: begin
                    pbus_enable_o <= 1'b1;
                    to_cnt        <= '0;
                    state         <= ST_ACCESS;
                end
                ST_ACCESS: begin
                    if (pbus_ready_i) begin
                        pbus_sel_o    <= 1'b0;
                        pbus_enable_o <= 1'b0;
                        rsp_valid_o   <= 1'b1;
                        rsp_err_o     <= pbus_slverr_i;
                        rsp_timeout_o <= 1'b0;
                        rsp_rdata_o   <= (pbus_write_o || pbus_slverr_i) ? '0 : pbus_rdata_i;
                        state         <= ST_RESP;
                    end else if (to_hit) begin
                        pbus_sel_o    <= 1'b0;
                        pbus_enable_o <= 1'b0;
                        rsp_valid_o   <= 1'b1;
                        rsp_err_o     <= 1'b1;
                        rsp_timeout_o <= 1'b1;
                        rsp_rdata_o   <= '0;
                        state         <= ST_RESP;
                    end else if (to_cnt != '1) begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready_i) begin
                        rsp_valid_o <= 1'b0;
                        cmd_ready_o <= 1'b1;
                        state       <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pbus_master.sv
// tb_pbus_master: self-checking bench for pbus_master (TIMEOUT_CYCLES=4).
// Directed table of transactions, a reset-in-ACCESS sequence, and randomized
// transactions checked against a cycle-count/result model of the transfer rules.
module tb_pbus_master;

    localparam int unsigned T      = 4;
    localparam int unsigned BUDGET = 40;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_write = 1'b0;
    logic [31:0] cmd_addr  = '0;
    logic [31:0] cmd_wdata = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        rsp_timeout;
    logic [31:0] bus_addr;
    logic        bus_write;
    logic        bus_sel;
    logic        bus_enable;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata  = '0;
    logic        bus_ready  = 1'b0;
    logic        bus_slverr = 1'b0;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    pbus_master #(.TIMEOUT_CYCLES(T), .TO_W(8)) dut (
        .pbus_clk      (clk),
        .pbus_rst      (rst),
        .cmd_valid_i   (cmd_valid),
        .cmd_ready_o   (cmd_ready),
        .cmd_write_i   (cmd_write),
        .cmd_addr_i    (cmd_addr),
        .cmd_wdata_i   (cmd_wdata),
        .rsp_valid_o   (rsp_valid),
        .rsp_ready_i   (rsp_ready),
        .rsp_rdata_o   (rsp_rdata),
        .rsp_err_o     (rsp_err),
        .rsp_timeout_o (rsp_timeout),
        .pbus_addr_o   (bus_addr),
        .pbus_write_o  (bus_write),
        .pbus_sel_o    (bus_sel),
        .pbus_enable_o (bus_enable),
        .pbus_wdata_o  (bus_wdata),
        .pbus_rdata_i  (bus_rdata),
        .pbus_ready_i  (bus_ready),
        .pbus_slverr_i (bus_slverr)
    );

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        slverr;
        int unsigned waits;
        int unsigned hold;
        int unsigned e_lat;
        logic [31:0] e_rdata;
        logic        e_err;
        logic        e_to;
    } vec_t;

    typedef struct {
        int unsigned lat;
        logic [31:0] rdata;
        logic        err;
        logic        to;
    } res_t;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, want);
        end
    endtask

    // Outcome of one command from the transfer rules: cycles from accept to
    // rsp_valid and the response fields. waits = not-ready ACCESS cycles.
    function automatic res_t model(input logic wr, input logic [31:0] addr,
                                   input logic [31:0] rdata, input logic slverr,
                                   input int unsigned waits);
        res_t r;
        if (addr[1:0] != 2'b00) begin
            r = '{lat: 1, rdata: 32'h0, err: 1'b1, to: 1'b0};
        end else if (T != 0 && waits >= T) begin
            r = '{lat: 2 + T, rdata: 32'h0, err: 1'b1, to: 1'b1};
        end else begin
            r.lat   = 3 + waits;
            r.err   = slverr;
            r.to    = 1'b0;
            r.rdata = (wr || slverr) ? 32'h0 : rdata;
        end
        return r;
    endfunction

    task automatic run_txn(input vec_t v);
        int unsigned k;
        int unsigned acc;
        bit          got;
        cmd_write = v.wr;
        cmd_addr  = v.addr;
        cmd_wdata = v.wdata;
        cmd_valid = 1'b1;
        chk("cmd_ready_idle", 128'(cmd_ready), 128'(1'b1));
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_addr  = $urandom;
        cmd_wdata = $urandom;
        cmd_write = 1'($urandom);
        k = 1; acc = 0; got = 0;
        while (k <= BUDGET && !got) begin
            if (rsp_valid) begin
                got = 1;
            end else begin
                chk("bus_phase", 128'({bus_sel, bus_enable, bus_write, bus_addr, bus_wdata, cmd_ready}),
                    128'({1'b1, 1'(k >= 2), v.wr, v.addr, v.wdata, 1'b0}));
                if (bus_enable) begin
                    acc++;
                    if (acc == v.waits + 1) begin
                        bus_ready  = 1'b1;
                        bus_rdata  = v.rdata;
                        bus_slverr = v.slverr;
                    end else begin
                        bus_ready  = 1'b0;
                        bus_rdata  = $urandom;
                        bus_slverr = 1'($urandom);
                    end
                end else begin
                    bus_ready  = 1'($urandom);
                    bus_rdata  = $urandom;
                    bus_slverr = 1'($urandom);
                end
                @(negedge clk);
                k++;
            end
        end
        bus_ready = 1'b0;
        if (!got) chk("rsp_seen", 128'(1'b0), 128'(1'b1));
        chk("latency", 128'(k), 128'(v.e_lat));
        chk("rsp_fields", 128'({rsp_rdata, rsp_err, rsp_timeout, bus_sel, bus_enable}),
            128'({v.e_rdata, v.e_err, v.e_to, 1'b0, 1'b0}));
        for (int unsigned h = 0; h < v.hold; h++) begin
            @(negedge clk);
            chk("rsp_hold", 128'({rsp_valid, rsp_rdata, rsp_err, rsp_timeout, cmd_ready, bus_sel}),
                128'({1'b1, v.e_rdata, v.e_err, v.e_to, 1'b0, 1'b0}));
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("rsp_release", 128'({rsp_valid, cmd_ready}), 128'({1'b0, 1'b1}));
    endtask

    task automatic chk_reset_state(input string name);
        chk(name, 128'({cmd_ready, rsp_valid, rsp_err, rsp_timeout, bus_write, bus_sel, bus_enable}),
            128'(7'b1000000));
        chk({name, "_data"}, 128'({rsp_rdata, bus_addr, bus_wdata}), 128'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t tbl[8];
        vec_t v;
        res_t r;
        int unsigned n;

        tbl[0] = '{1'b1, 32'h0000_0010, 32'h0000_ABCD, 32'h0,         1'b0, 0,  0, 3, 32'h0,         1'b0, 1'b0};
        tbl[1] = '{1'b0, 32'h0000_0020, 32'h0,         32'h0000_1234, 1'b0, 3,  0, 6, 32'h0000_1234, 1'b0, 1'b0};
        tbl[2] = '{1'b0, 32'h0000_0030, 32'h0,         32'h1111_2222, 1'b0, 50, 0, 6, 32'h0,         1'b1, 1'b1};
        tbl[3] = '{1'b0, 32'h0000_0034, 32'h0,         32'h5A5A_A5A5, 1'b0, 3,  0, 6, 32'h5A5A_A5A5, 1'b0, 1'b0};
        tbl[4] = '{1'b1, 32'h0000_0038, 32'h0000_0777, 32'h0,         1'b0, 4,  0, 6, 32'h0,         1'b1, 1'b1};
        tbl[5] = '{1'b0, 32'h0000_0040, 32'h0,         32'hFFFF_FFFF, 1'b1, 1,  0, 4, 32'h0,         1'b1, 1'b0};
        tbl[6] = '{1'b0, 32'h0000_0003, 32'h0,         32'hDEAD_BEEF, 1'b0, 0,  0, 1, 32'h0,         1'b1, 1'b0};
        tbl[7] = '{1'b0, 32'h0000_0044, 32'h0,         32'hCAFE_0001, 1'b0, 0,  5, 3, 32'hCAFE_0001, 1'b0, 1'b0};

        repeat (2) @(negedge clk);
        chk_reset_state("reset_in");
        rst = 1'b0;
        @(negedge clk);
        chk_reset_state("reset_idle");

        for (int i = 0; i < 8; i++) run_txn(tbl[i]);

        // Reset during ACCESS drops the transfer with no response.
        cmd_write = 1'b0;
        cmd_addr  = 32'h0000_0050;
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        n = 0;
        while (!bus_enable && n < BUDGET) begin
            @(negedge clk);
            n++;
        end
        chk("reach_access", 128'({bus_sel, bus_enable}), 128'(2'b11));
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk_reset_state("reset_mid");
        @(negedge clk);
        chk("reset_no_rsp", 128'({rsp_valid, cmd_ready, bus_sel}), 128'(3'b010));

        for (int i = 0; i < 40; i++) begin
            v.wr     = 1'($urandom);
            v.addr   = $urandom;
            if ($urandom_range(0, 3) != 0) v.addr[1:0] = 2'b00;
            v.wdata  = $urandom;
            v.rdata  = $urandom;
            v.slverr = ($urandom_range(0, 4) == 0);
            v.waits  = $urandom_range(0, 6);
            v.hold   = $urandom_range(0, 3);
            r = model(v.wr, v.addr, v.rdata, v.slverr, v.waits);
            v.e_lat   = r.lat;
            v.e_rdata = r.rdata;
            v.e_err   = r.err;
            v.e_to    = r.to;
            run_txn(v);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
